// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t    : fetch FSM state encoding
//   DEFAULT_RESET_PC : default PC loaded on reset
//   INSN_W           : instruction word width
package pc_fetch_pkg;

  localparam int          INSN_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end owning the program counter.
// Issues one word fetch at a time, buffers the returned word in a
// single-entry register and hands it to decode with valid/ready.
// Ports:
//   clk, rst (async, active-low)
//   pc / pcAddr           : to / from the external PC adder (pcAddr = pc + 4)
//   redirect_valid/_pc    : branch/jump redirect, target word-aligned here
//   imem_req_*            : fetch request channel (addr always equals pc)
//   imem_rsp_*            : fetch response, one per accepted request
//   inst_valid/_data/_pc  : buffered instruction to decode
//   inst_ready            : decode accepts the instruction
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pcAddr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INSN_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  fetch_state_t      state, state_nxt;
  logic              kill, kill_nxt;
  logic [ADDR_W-1:0] pc_r, pc_nxt;
  logic              capture;
  logic [ADDR_W-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Next-state logic. A redirect always wins; kill marks the single
  // in-flight response as stale when the request was already accepted.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    pc_nxt    = pc_r;
    capture   = 1'b0;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
          if (imem_req_ready) begin
            kill_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
          if (imem_rsp_valid) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            kill_nxt = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill) begin
            // pc already holds the redirect target; just refetch
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pcAddr;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_tgt;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  // State, PC and instruction buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      kill      <= 1'b0;
      pc_r      <= RESET_PC;
      inst_data <= '0;
      inst_pc   <= '0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      pc_r  <= pc_nxt;
      if (capture) begin
        inst_data <= imem_rsp_data;
        inst_pc   <= pc_r;
      end
    end
  end

  assign pc             = pc_r;
  assign imem_req_addr  = pc_r;
  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_HOLD);

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end that owns the program counter. It drives the current PC to the existing PC adder and consumes the adder's PC+4 result, applying branch/jump redirects. It issues one word fetch at a time to instruction memory over a valid/ready request channel. It then buffers the returned instruction in a single-entry skid register and presents it to decode with a valid/ready handshake.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-low.
- pc  out  ADDR_W  current PC, driven to the PC adder input.
- pcAddr  in  ADDR_W  PC+4 returned combinationally by the PC adder.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0 internally.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_W  fetch address; always equals pc.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  fetch data valid; exactly one response per accepted request.
- imem_rsp_data  in  32  fetched instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_data  out  32  buffered instruction.
- inst_pc  out  ADDR_W  address of inst_data.
- inst_ready  in  1  decode accepts the instruction.

## Operation
- FSM states are S_BOOT, S_REQ, S_WAIT, S_HOLD, plus a kill flag marking the one in-flight response as stale.
- S_BOOT:
  - Entered on reset.
  - Unconditionally goes to S_REQ on the next edge.
  - Ignores redirects.
- S_REQ:
  - Drives imem_req_valid=1.
  - On imem_req_ready, goes to S_WAIT.
- S_WAIT:
  - On imem_rsp_valid with kill=0: inst_data←imem_rsp_data, inst_pc←pc, pc←pcAddr, go to S_HOLD.
  - On imem_rsp_valid with kill=1: discard the data, clear kill, go to S_REQ (pc already holds the target).
- S_HOLD:
  - Drives inst_valid=1.
  - On inst_ready, goes to S_REQ.
- Redirect always has priority and sets pc←{redirect_pc[ADDR_W-1:2],2'b00}:
  - In S_REQ without ready: stay in S_REQ. The address changes next cycle, and the un-accepted request for the old address may be withdrawn.
  - In S_REQ with ready in the same cycle: the old request was accepted. Set kill←1 and go to S_WAIT.
  - In S_WAIT without rsp_valid: set kill←1 and stay in S_WAIT.
  - In S_WAIT with rsp_valid in the same cycle: drop the response, clear kill, go to S_REQ.
  - In S_HOLD, with or without inst_ready: the instruction is dropped (or consumed if ready), go to S_REQ.
- An imem_rsp_valid arriving outside S_WAIT is ignored.
- Arithmetic: pc+4 comes only from pcAddr. Wrap-around at 32'hFFFF_FFFC → 32'h0000_0000 is inherited from the adder; there is no overflow flag.

## Timing
- Reset values (asserted asynchronously):
  - pc=RESET_PC; inst_pc=0; inst_data=0.
  - inst_valid=0; imem_req_valid=0.
  - kill=0; state=S_BOOT.
- The first imem_req_valid appears in the first cycle after reset deasserts plus one edge (S_BOOT→S_REQ).
- Minimum fetch loop, with ready and response each arriving one cycle after entry:
  - S_REQ (1) → S_WAIT (1) → S_HOLD (1).
  - This gives 3 cycles per instruction.
- pc changes only when a response is captured or on a redirect.
- imem_req_addr is stable while imem_req_valid=1 && !imem_req_ready, unless a redirect occurs.
- inst_valid, inst_data and inst_pc are registered and stable while inst_valid && !inst_ready.
- Reset asserted mid-operation:
  - Aborts any request or response immediately.
  - A response arriving after reset deasserts is ignored, because the FSM is not yet in S_WAIT.

## Structure
- Package pc_fetch_pkg holds:
  - the fetch_state_t enum (S_BOOT, S_REQ, S_WAIT, S_HOLD);
  - the DEFAULT_RESET_PC constant;
  - the INSN_W=32 constant.
- No internal sub-module. The existing pcAdder is instantiated beside this block at the top level, with pc connected to its pc input and pcAddr to its output.
- The single-entry instruction buffer is plain registers inside this block.

## Test plan
- Reset/boot: hold rst=0, then release.
  - Outputs stay at reset values for one cycle.
  - imem_req_valid=1 with imem_req_addr=0x0 on the following cycle.
- Sequential fetch, with memory always ready and returning 0xA0+addr one cycle after acceptance, and inst_ready=1:
  - inst_pc sequence 0x0, 0x4, 0x8.
  - One inst_valid every 3 cycles.
- Decode stall: inst_ready=0 for 5 cycles with inst 0x00000013 at pc 0x8.
  - inst_valid, inst_data and inst_pc are held constant.
  - No new request is issued.
  - On release, the next request goes to 0xC.
- Redirect in S_WAIT: redirect_pc=0x100 while a fetch of 0x4 is outstanding.
  - The 0x4 response is discarded (inst_valid stays 0).
  - The next request is to 0x100.
- Redirect coincident with imem_req_ready in S_REQ: redirect_pc=0x203.
  - The stale response is dropped.
  - The next request is to 0x200 (low bits cleared).
- Wrap-around: RESET_PC=0xFFFFFFFC.
  - After the first fetch completes, the next request is to 0x00000000.
